// File: rtl/vgasyncdecode_if.sv
// Sync-in / coordinates-out bundle for the VGA timing decoder.
// The master side drives HS/VS; the slave side (the decoder) returns the recovered timing.
interface vgasyncdecode_if;
  logic       HS;
  logic       VS;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [9:0] line_len;
  logic [9:0] hs_width;
  logic       locked;
  logic       de;
  logic       frame_start;

  modport master (
    output HS, VS,
    input  hcount, vcount, line_len, hs_width, locked, de, frame_start
  );

  modport slave (
    input  HS, VS,
    output hcount, vcount, line_len, hs_width, locked, de, frame_start
  );
endinterface

// File: rtl/vgasyncdecode.sv
// Rebuilds pixel/line coordinates from sampled HS/VS, measures line period and sync width,
// qualifies lock over consecutive good lines and produces a registered display enable.
module vgasyncdecode #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT       = 640,
  parameter int V_ACT_START = 35,
  parameter int V_ACT       = 480,
  parameter int LOCK_LINES  = 4
) (
  input  logic       clk25M,
  input  logic       reset_n,
  vgasyncdecode_if.slave vga
);

  localparam logic [9:0] CNT_MAX   = 10'h3FF;
  localparam logic [9:0] H_TOTAL_W = 10'(H_TOTAL);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] H_LO      = 10'(H_ACT_START);
  localparam logic [9:0] H_HI      = 10'(H_ACT_START + H_ACT);
  localparam logic [9:0] V_LO      = 10'(V_ACT_START);
  localparam logic [9:0] V_HI      = 10'(V_ACT_START + V_ACT);
  localparam logic [3:0] LOCK_W    = 4'(LOCK_LINES);

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] match_q, match_d;
  logic       hs_q, hs_p, vs_q, vs_p;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic [9:0] line_len_q, line_len_d;
  logic [9:0] hsw_cnt_q, hsw_cnt_d;
  logic [9:0] hs_width_q, hs_width_d;
  logic       vs_pend_q, vs_pend_d;
  logic       frame_start_q, frame_start_d;
  logic       locked_q;
  logic       de_q, de_d;

  logic       hs_rise, hs_fall, vs_rise;
  logic [9:0] line_len_new;
  logic       good_line, timeout;

  assign hs_rise = hs_q & ~hs_p;
  assign hs_fall = ~hs_q & hs_p;
  assign vs_rise = vs_q & ~vs_p;

  // Period of the line just ended is the pre-reset hcount plus the rise clock itself.
  assign line_len_new = (hcount_q == CNT_MAX) ? CNT_MAX : hcount_q + 10'd1;
  assign good_line    = (line_len_new == H_TOTAL_W) && (hs_width_q == H_SYNC_W);
  assign timeout      = (hcount_q == CNT_MAX) && !hs_rise;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    if (timeout) begin
      state_d = HUNT;
      match_d = '0;
    end else if (hs_rise) begin
      case (state_q)
        HUNT: begin
          state_d = CHECK;
          match_d = '0;
        end
        CHECK: begin
          if (good_line) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_W) state_d = LOCKED;
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (!good_line) begin
            state_d = CHECK;
            match_d = '0;
          end
        end
        default: begin
          state_d = HUNT;
          match_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    hcount_d      = (hcount_q == CNT_MAX) ? CNT_MAX : hcount_q + 10'd1;
    line_len_d    = line_len_q;
    hsw_cnt_d     = hsw_cnt_q;
    hs_width_d    = hs_width_q;
    vcount_d      = vcount_q;
    vs_pend_d     = vs_pend_q | vs_rise;
    frame_start_d = 1'b0;

    if (hs_rise) begin
      hcount_d   = '0;
      line_len_d = line_len_new;
      // The rise clock is the first high sample of the new sync pulse.
      hsw_cnt_d  = 10'd1;
      if (vs_pend_q || vs_rise) begin
        vcount_d      = '0;
        vs_pend_d     = 1'b0;
        frame_start_d = 1'b1;
      end else begin
        vcount_d = (vcount_q == CNT_MAX) ? CNT_MAX : vcount_q + 10'd1;
      end
    end else if (hs_q && hsw_cnt_q != CNT_MAX) begin
      hsw_cnt_d = hsw_cnt_q + 10'd1;
    end

    if (hs_fall) hs_width_d = hsw_cnt_q;

    de_d = locked_q && (hcount_q >= H_LO) && (hcount_q < H_HI)
                    && (vcount_q >= V_LO) && (vcount_q < V_HI);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= HUNT;
      match_q       <= '0;
      hs_q          <= 1'b0;
      hs_p          <= 1'b0;
      vs_q          <= 1'b0;
      vs_p          <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      line_len_q    <= '0;
      hsw_cnt_q     <= '0;
      hs_width_q    <= '0;
      vs_pend_q     <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      de_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      match_q       <= match_d;
      hs_q          <= vga.HS;
      hs_p          <= hs_q;
      vs_q          <= vga.VS;
      vs_p          <= vs_q;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      line_len_q    <= line_len_d;
      hsw_cnt_q     <= hsw_cnt_d;
      hs_width_q    <= hs_width_d;
      vs_pend_q     <= vs_pend_d;
      frame_start_q <= frame_start_d;
      locked_q      <= (state_d == LOCKED);
      de_q          <= de_d;
    end
  end

  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.line_len    = line_len_q;
  assign vga.hs_width    = hs_width_q;
  assign vga.locked      = locked_q;
  assign vga.de          = de_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vgasyncdecode.sv
// Bench for vgasyncdecode: event-level reference model of the sampled sync stream,
// per-cycle comparison, plus literal expectations for the headline scenarios.
module tb_vgasyncdecode;

  localparam int CNT_MAX = 1023;

  logic clk25M  = 1'b0;
  logic reset_n = 1'b0;
  logic chk_en  = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  vgasyncdecode_if vga ();

  vgasyncdecode dut (
    .clk25M (clk25M),
    .reset_n(reset_n),
    .vga    (vga)
  );

  always #20 clk25M = ~clk25M;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // Reference model, in terms of sample history: s1/s2 are the HS samples one and two
  // clocks back; a rise becomes visible at the clock after it is sampled.
  int e_edge, e_last_rise, e_run2, e_consec;
  int e_hcount, e_vcount, e_linelen, e_width;
  bit e_s1, e_s2, e_v1, e_v2, e_pend, e_acq;
  bit e_locked, e_de, e_fs;

  task automatic model_reset();
    e_edge = 0;  e_last_rise = 0; e_run2 = 0; e_consec = 0;
    e_hcount = 0; e_vcount = 0; e_linelen = 0; e_width = 0;
    e_s1 = 0; e_s2 = 0; e_v1 = 0; e_v2 = 0; e_pend = 0; e_acq = 0;
    e_locked = 0; e_de = 0; e_fs = 0;
  endtask

  task automatic model_step();
    bit rise, fall, vrise, good, old_lock;
    int old_h, old_v, len;
    e_edge++;
    rise  = e_s1 && !e_s2;
    fall  = !e_s1 && e_s2;
    vrise = e_v1 && !e_v2;
    old_h = e_hcount;
    old_v = e_vcount;
    old_lock = e_locked;

    if (fall) e_width = sat(e_run2);

    e_fs = 0;
    if (rise) begin
      len  = sat(e_edge - e_last_rise);
      good = (len == 800) && (e_width == 96);
      if (!e_acq) begin
        e_acq = 1; e_consec = 0;
      end else if (good) e_consec++;
      else e_consec = 0;
      e_linelen   = len;
      e_last_rise = e_edge;
      if (e_pend || vrise) begin
        e_vcount = 0; e_pend = 0; e_fs = 1;
      end else e_vcount = sat(e_vcount + 1);
    end else begin
      if (old_h == CNT_MAX) begin
        e_acq = 0; e_consec = 0;
      end
      if (vrise) e_pend = 1;
    end

    e_locked = e_acq && (e_consec >= 4);
    e_hcount = sat(e_edge - e_last_rise);
    e_de     = old_lock && old_h >= 144 && old_h < 784 && old_v >= 35 && old_v < 515;

    e_run2 = e_s1 ? e_run2 + 1 : 0;
    e_s2 = e_s1; e_s1 = vga.HS;
    e_v2 = e_v1; e_v1 = vga.VS;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk25M or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Compare process, plus a few observations used by the literal checks.
  int  prev_h = 0, n_wrap = 0, n_fs = 0, de_h = -1, de_v = -1;
  bit  de_seen = 0;

  initial forever begin
    @(negedge clk25M);
    if (reset_n && chk_en) begin
      check("hcount",      vga.hcount,      e_hcount);
      check("vcount",      vga.vcount,      e_vcount);
      check("line_len",    vga.line_len,    e_linelen);
      check("hs_width",    vga.hs_width,    e_width);
      check("locked",      vga.locked,      e_locked);
      check("de",          vga.de,          e_de);
      check("frame_start", vga.frame_start, e_fs);
      if (prev_h == 799 && vga.hcount == 0) n_wrap++;
      prev_h = vga.hcount;
      if (vga.frame_start) n_fs++;
      if (vga.de && !de_seen) begin
        de_seen = 1; de_h = vga.hcount; de_v = vga.vcount;
      end
    end
  end

  task automatic step(input bit hs, input bit vs);
    @(negedge clk25M);
    vga.HS = hs;
    vga.VS = vs;
  endtask

  // One source line; VS goes high at column vs_at (if >= 0) and stays high to line end.
  task automatic line(input int period, input int width, input int vs_at);
    for (int c = 0; c < period; c++) step(c < width, vs_at >= 0 && c >= vs_at);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hcount"},   vga.hcount,   0);
    check({tag, "_vcount"},   vga.vcount,   0);
    check({tag, "_line_len"}, vga.line_len, 0);
    check({tag, "_hs_width"}, vga.hs_width, 0);
    check({tag, "_locked"},   vga.locked,   0);
    check({tag, "_de"},       vga.de,       0);
    check({tag, "_fs"},       vga.frame_start, 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vga.HS = 1'b0;
    vga.VS = 1'b0;
    repeat (3) @(negedge clk25M);
    #1 check_all_zero("reset");
    @(negedge clk25M);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Nominal stream with a frame start on the first line.
    line(800, 96, 0);
    for (int i = 1; i < 4; i++) line(800, 96, -1);
    check("lock_after_4_rises", vga.locked, 0);
    line(800, 96, -1);
    check("lock_after_5_rises", vga.locked, 1);
    check("nominal_line_len", vga.line_len, 800);
    check("nominal_hs_width", vga.hs_width, 96);
    for (int i = 5; i < 38; i++) line(800, 96, -1);
    check("hcount_wrap_seen", int'(n_wrap > 0), 1);
    check("frame_start_pulses", n_fs, 1);
    check("first_de_hcount", de_h, 145);
    check("first_de_vcount", de_v, 35);

    // One long line drops lock; four good lines restore it.
    line(801, 96, -1);
    line(800, 96, -1);
    check("long_line_unlock", vga.locked, 0);
    check("long_line_len", vga.line_len, 801);
    for (int i = 0; i < 3; i++) line(800, 96, -1);
    check("relock_not_yet", vga.locked, 0);
    line(800, 96, -1);
    check("relock_after_4", vga.locked, 1);

    // HS stuck low: hcount saturates and the decoder goes back to hunting.
    for (int i = 0; i < 1100; i++) step(0, 0);
    check("timeout_hcount", vga.hcount, 1023);
    check("timeout_locked", vga.locked, 0);
    check("timeout_de", vga.de, 0);
    line(800, 96, -1);
    check("timeout_line_len", vga.line_len, 1023);
    for (int i = 0; i < 3; i++) line(800, 96, -1);
    check("timeout_relock_not_yet", vga.locked, 0);
    line(800, 96, -1);
    check("timeout_relock", vga.locked, 1);

    // Sync width one short: never qualifies.
    for (int i = 0; i < 7; i++) line(800, 95, -1);
    check("narrow_sync_locked", vga.locked, 0);
    check("narrow_sync_width", vga.hs_width, 95);
    for (int i = 0; i < 5; i++) line(800, 96, -1);
    check("narrow_then_relock", vga.locked, 1);

    // Randomised periods, widths, sync dropouts and VS placement.
    for (int i = 0; i < 15; i++) begin
      int r, p, w, va;
      r  = $urandom_range(0, 9);
      p  = (r < 6) ? 800 : (r < 9) ? $urandom_range(790, 810) : 1030;
      w  = ($urandom_range(0, 3) == 0) ? $urandom_range(90, 100) : 96;
      va = ($urandom_range(0, 4) == 0) ? $urandom_range(0, p - 1) : -1;
      line(p, w, va);
    end
    for (int i = 0; i < 5; i++) line(800, 96, -1);
    check("pre_reset_locked", vga.locked, 1);

    // Asynchronous reset in the middle of a locked line.
    for (int c = 0; c < 300; c++) step(c < 96, 0);
    #5 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    for (int c = 300; c < 800; c++) begin
      step(0, 0);
      if (c == 302) reset_n = 1'b1;
    end
    for (int i = 0; i < 4; i++) line(800, 96, -1);
    check("post_reset_not_yet", vga.locked, 0);
    line(800, 96, -1);
    check("post_reset_relock", vga.locked, 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
